// File: rtl/sobel_obf_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_obf_sched_if
// Brief    : Host request/response and Sobel core control bundle for the
//            frame scheduler. slave = scheduler side, master = host/core side.
// Revision : 1.0
// ============================================================================
interface sobel_obf_sched_if #(
    parameter int unsigned KEY_W = 3
) ();
    logic             req_valid;
    logic             req_ready;
    logic [KEY_W-1:0] req_key;
    logic             core_ap_start;
    logic             core_ap_done;
    logic             core_ap_idle;
    logic [KEY_W-1:0] core_working_key;
    logic             core_rst;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_status;
    logic [23:0]      resp_cycles;
    logic [15:0]      frame_cnt;

    modport slave (
        input  req_valid, req_key, core_ap_done, core_ap_idle, resp_ready,
        output req_ready, core_ap_start, core_working_key, core_rst,
               resp_valid, resp_status, resp_cycles, frame_cnt
    );

    modport master (
        output req_valid, req_key, core_ap_done, core_ap_idle, resp_ready,
        input  req_ready, core_ap_start, core_working_key, core_rst,
               resp_valid, resp_status, resp_cycles, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sobel_obf_sched.sv
`default_nettype none
// ============================================================================
// Module   : sobel_obf_sched
// Brief    : Job scheduler and watchdog for the key-obfuscated Sobel core.
//            Optional macro SOBEL_SCHED_KEY_HIDE_EN zeroes the key pins
//            outside RUN/FLUSH.
// Revision : 1.0
// ============================================================================
module sobel_obf_sched #(
    parameter int unsigned KEY_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 24'hFF_FFFF,
    parameter int unsigned RST_CYCLES     = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    sobel_obf_sched_if.slave bus
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_RUN        = 2'd1;
    localparam logic [1:0]  c_FLUSH      = 2'd2;
    localparam logic [1:0]  c_RESP       = 2'd3;
    localparam logic [1:0]  c_ST_OK      = 2'b00;
    localparam logic [1:0]  c_ST_TIMEOUT = 2'b01;
    localparam logic [23:0] c_TO_LAST    = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] c_TO_VAL     = 24'(TIMEOUT_CYCLES);
    localparam logic [3:0]  c_FL_LAST    = 4'(RST_CYCLES - 1);

    logic [1:0]       state_q,  state_d;
    logic [23:0]      cyc_q,    cyc_d;
    logic [3:0]       flush_q,  flush_d;
    logic [KEY_W-1:0] key_q,    key_d;
    logic [1:0]       status_q, status_d;
    logic [23:0]      cycles_q, cycles_d;
    logic [15:0]      frame_q,  frame_d;
    logic             idle_q, start_q, crst_q, resp_valid_q;
    logic             w_accept;

    // req_ready is the only output with a combinational path (core_ap_idle).
    assign bus.req_ready = idle_q & bus.core_ap_idle;
    assign w_accept      = (state_q == c_IDLE) && idle_q && bus.core_ap_idle && bus.req_valid;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        flush_d  = flush_q;
        key_d    = key_q;
        status_d = status_q;
        cycles_d = cycles_q;
        frame_d  = frame_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    key_d   = bus.req_key;
                    cyc_d   = '0;
                    flush_d = '0;
                    state_d = c_RUN;
                end
            end
            c_RUN: begin
                cyc_d = cyc_q + 24'd1;
                // Done has priority over the watchdog on the same cycle.
                if (bus.core_ap_done) begin
                    cycles_d = cyc_q + 24'd1;
                    status_d = c_ST_OK;
                    state_d  = c_RESP;
                end else if (cyc_q == c_TO_LAST) begin
                    cycles_d = c_TO_VAL;
                    status_d = c_ST_TIMEOUT;
                    state_d  = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (flush_q == c_FL_LAST) begin
                    state_d = c_RESP;
                end else begin
                    flush_d = flush_q + 4'd1;
                end
            end
            c_RESP: begin
                if (bus.resp_ready) begin
                    state_d = c_IDLE;
                    if (status_q == c_ST_OK) begin
                        frame_d = frame_q + 16'd1;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= c_IDLE;
            cyc_q        <= '0;
            flush_q      <= '0;
            key_q        <= '0;
            status_q     <= c_ST_OK;
            cycles_q     <= '0;
            frame_q      <= '0;
            idle_q       <= 1'b0;
            start_q      <= 1'b0;
            crst_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            flush_q      <= flush_d;
            key_q        <= key_d;
            status_q     <= status_d;
            cycles_q     <= cycles_d;
            frame_q      <= frame_d;
            idle_q       <= (state_d == c_IDLE);
            start_q      <= (state_d == c_RUN);
            crst_q       <= (state_d == c_FLUSH);
            resp_valid_q <= (state_d == c_RESP);
        end
    end

`ifdef SOBEL_SCHED_KEY_HIDE_EN
    logic [KEY_W-1:0] wkey_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wkey_q <= '0;
        end else if ((state_d == c_RUN) || (state_d == c_FLUSH)) begin
            wkey_q <= key_d;
        end else begin
            wkey_q <= '0;
        end
    end

    assign bus.core_working_key = wkey_q;
`else
    assign bus.core_working_key = key_q;
`endif

    assign bus.core_ap_start = start_q;
    assign bus.core_rst      = crst_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_status   = status_q;
    assign bus.resp_cycles   = cycles_q;
    assign bus.frame_cnt     = frame_q;

endmodule
`default_nettype wire

// File: doc/sobel_obf_sched.md
# sobel_obf_sched

Job scheduler and watchdog in front of the key-obfuscated Sobel HLS core.
- Accepts one frame request at a time, each carrying a working key, and drives the core's `ap_start`/`working_key` pins.
- Waits for `ap_done`, then returns a status and a cycle count.
- A wrong key can leave the core looping forever. A cycle-count watchdog detects this, pulses a reset into the core and reports a timeout instead of hanging the host.

## Interface
Parameters:
- `KEY_W`, 3, working key width
- `TIMEOUT_CYCLES`, 24'hFF_FFFF, maximum run cycles before abort; legal range 2..2^24-1
- `RST_CYCLES`, 4, length of the core reset pulse after a timeout; legal range 1..15

Ports:
- `ap_clk`  in  1  clock
- `ap_rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  frame request
- `req_ready`  out  1  scheduler can accept a request
- `req_key`  in  KEY_W  key for this frame
- `core_ap_start`  out  1  to the core's `ap_start`
- `core_ap_done`  in  1  from the core's `ap_done`
- `core_ap_idle`  in  1  from the core's `ap_idle`
- `core_working_key`  out  KEY_W  to the core's `working_key`
- `core_rst`  out  1  synchronous reset to the core, ORed with system reset at the top level
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  host takes the response
- `resp_status`  out  2  00 = OK, 01 = TIMEOUT; 1x is never produced
- `resp_cycles`  out  24  number of cycles `core_ap_start` was high for this frame
- `frame_cnt`  out  16  count of frames that completed OK; wraps from FFFF to 0000

## Operation
States: IDLE, RUN, FLUSH, RESP. Reset state is IDLE.

- **IDLE**
  - `req_ready = core_ap_idle`.
  - On `req_valid & req_ready`: latch `req_key` into `core_working_key`, clear the cycle counter and the flush counter, go to RUN.
- **RUN**
  - `core_ap_start = 1`; the cycle counter increments every RUN cycle.
  - If `core_ap_done = 1`: set `resp_cycles` = counter + 1, `resp_status = 00`, go to RESP.
  - Else if counter == `TIMEOUT_CYCLES` - 1: set `resp_cycles = TIMEOUT_CYCLES`, `resp_status = 01`, go to FLUSH.
  - `core_ap_done` and the timeout in the same cycle: done wins and the frame is reported OK.
  - `core_ap_idle` is ignored in RUN.
- **FLUSH**
  - `core_ap_start = 0`, `core_rst = 1` for exactly `RST_CYCLES` cycles, then go to RESP.
- **RESP**
  - `resp_valid = 1`; `resp_status` and `resp_cycles` are held stable.
  - On `resp_ready`: go to IDLE; if the status is OK, increment `frame_cnt`.
- `req_ready = 0` in every state except IDLE.
- `core_ap_start`, `core_rst`, `req_ready` and `resp_valid` are registered decodes of the next state. They are not combinational from the inputs, except `req_ready`, which is gated by `core_ap_idle`.
- Reset values: state IDLE, all 1-bit outputs 0, `core_working_key` 0, `resp_status` 00, `resp_cycles` 0, `frame_cnt` 0.
- Asserting `ap_rst` mid-frame aborts immediately; no response is generated for the aborted frame.

## Timing
- Request accepted at clock edge T → `core_ap_start = 1` from T+1.
- `core_ap_done` sampled high at edge D → `core_ap_start = 0` and `resp_valid = 1` from D+1. The core therefore never sees `ap_start` high in its first state after done, so it is not relaunched.
- Timeout: the RUN cycle with counter == `TIMEOUT_CYCLES`-1 → FLUSH from the next cycle, then `RST_CYCLES` cycles of `core_rst` → `resp_valid` from the following cycle.
- `resp_valid` and `resp_ready` high at edge R → `resp_valid = 0` at R+1. A new request can be accepted at R+1 at the earliest, so back-to-back frames are spaced by one IDLE cycle.
- `core_working_key` is stable for the whole of RUN and FLUSH.

## Configuration
- `SOBEL_SCHED_KEY_HIDE_EN` defined: `core_working_key` is forced to 0 in IDLE and RESP. The latched key is driven only in RUN and FLUSH, which keeps it off the core pins between frames.
- Not defined: `core_working_key` holds the last latched key until the next request is accepted.

## Test plan
Bench uses `TIMEOUT_CYCLES = 20`, `RST_CYCLES = 4`, and a core model that raises `ap_done` N cycles after `ap_start` rises.

- **Normal frame:** key 3'b101, N = 6 → `core_ap_start` high for 6 cycles; `resp_valid` one cycle after done; status 00; `resp_cycles` 6; `frame_cnt` 0 → 1 on `resp_ready`.
- **Hung core:** model never raises done → `core_ap_start` high for 20 cycles, then `core_rst` high for 4 cycles; status 01; `resp_cycles` 20; `frame_cnt` unchanged.
- **Done on the timeout cycle:** N = 20 → status 00, `resp_cycles` 20, no `core_rst` pulse.
- **Backpressure and busy core:** hold `resp_ready = 0` for 10 cycles → `resp_valid` and the data stay stable and `req_ready` stays 0. Separately, `core_ap_idle = 0` in IDLE → `req_ready = 0` and the request is not accepted.
- **Reset mid-frame:** assert `ap_rst` for 1 cycle during RUN → all outputs return to their reset values immediately and no response is emitted. The next request runs normally.
- **Key hiding:** with `SOBEL_SCHED_KEY_HIDE_EN`, key 3'b111 → `core_working_key` 0 in IDLE and RESP, 3'b111 in RUN. Without the macro, 3'b111 is held after RESP.
